// File: rtl/mac_tx_frame_gen.sv
// Ethernet TX framing: header prepend, zero pad, and pacing for the serializer FIFO.
// Define MAC_TX_VLAN_EN to insert an 802.1Q tag between source MAC and EtherType.
module mac_tx_frame_gen #(
    parameter int unsigned MAX_LEN      = 1500,
    parameter int unsigned MIN_PAYLOAD  = 46,
    parameter int unsigned CYC_PER_BYTE = 8,
    parameter int unsigned OVERHEAD_CYC = 128
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [47:0] local_mac,
    input  logic [47:0] dst_mac,
    input  logic [15:0] eth_type,
`ifdef MAC_TX_VLAN_EN
    input  logic [15:0] vlan_tci,
`endif
    input  logic        ip_tx_req,
    input  logic [15:0] ip_tx_len,
    output logic        ip_tx_ack,
    output logic        ip_tx_rd,
    input  logic [7:0]  ip_tx_dat,
    output logic        mac_tx_sop,
    output logic        mac_tx_eop,
    output logic        mac_tx_vld,
    output logic [7:0]  mac_tx_dat,
    output logic        frame_busy,
    output logic        frame_err
);

`ifdef MAC_TX_VLAN_EN
    localparam int unsigned HDR = 18;
`else
    localparam int unsigned HDR = 14;
`endif
    localparam int unsigned HW = HDR * 8;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        PAD,
        PACE
    } state_t;

    state_t        state;
    logic [15:0]   pos;
    logic [15:0]   len_q;
    logic [15:0]   fb_q;
    logic [15:0]   lim_q;
    logic [15:0]   pace_cnt;
    logic [HW-1:0] hdr_q;

    logic [HW-1:0] hdr_next;
    logic [15:0]   fb_next;
    logic [15:0]   lim_next;
    logic [15:0]   rd_idx;
    logic          rd_next;
    logic          last_byte;
    logic          pay_last;
    logic          too_long;
    logic          pace_run;

    always_comb begin
`ifdef MAC_TX_VLAN_EN
        hdr_next = {dst_mac, local_mac, 16'h8100, vlan_tci, eth_type};
`else
        hdr_next = {dst_mac, local_mac, eth_type};
`endif
        too_long = ip_tx_len > 16'(MAX_LEN);
        fb_next  = 16'(HDR) + ((ip_tx_len < 16'(MIN_PAYLOAD))
                               ? 16'(MIN_PAYLOAD) : ip_tx_len);
        lim_next = fb_next * 16'(CYC_PER_BYTE)
                 + 16'(OVERHEAD_CYC) - 16'd1;
    end

    // Reads lead the output slot by two cycles: one for the
    // upstream read latency, one for the output register.
    always_comb begin
        rd_idx    = pos - 16'(HDR - 2);
        rd_next   = (pos >= 16'(HDR - 2)) && (rd_idx < len_q);
        last_byte = pos == fb_q - 16'd1;
        pay_last  = pos == 16'(HDR) + len_q - 16'd1;
        pace_run  = (state != IDLE) && !(state == HEAD && pos == 16'd0);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            pos        <= '0;
            len_q      <= '0;
            fb_q       <= '0;
            lim_q      <= '0;
            pace_cnt   <= '0;
            hdr_q      <= '0;
            ip_tx_ack  <= 1'b0;
            ip_tx_rd   <= 1'b0;
            mac_tx_sop <= 1'b0;
            mac_tx_eop <= 1'b0;
            mac_tx_vld <= 1'b0;
            mac_tx_dat <= '0;
            frame_busy <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ip_tx_ack  <= 1'b0;
            ip_tx_rd   <= 1'b0;
            mac_tx_sop <= 1'b0;
            mac_tx_eop <= 1'b0;
            mac_tx_vld <= 1'b0;
            mac_tx_dat <= '0;
            frame_err  <= 1'b0;

            if (pace_run) begin
                pace_cnt <= pace_cnt + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    // ack_q gate keeps a held request from being
                    // re-accepted on the cycle right after a reject.
                    if (ip_tx_req && !ip_tx_ack) begin
                        ip_tx_ack <= 1'b1;
                        len_q     <= ip_tx_len;
                        hdr_q     <= hdr_next;
                        fb_q      <= fb_next;
                        lim_q     <= lim_next;
                        pos       <= '0;
                        pace_cnt  <= '0;
                        if (too_long) begin
                            frame_err <= 1'b1;
                        end else begin
                            state      <= HEAD;
                            frame_busy <= 1'b1;
                        end
                    end
                end
                HEAD: begin
                    mac_tx_vld <= 1'b1;
                    mac_tx_sop <= pos == 16'd0;
                    mac_tx_eop <= last_byte;
                    mac_tx_dat <= hdr_q[HW-1 -: 8];
                    ip_tx_rd   <= rd_next;
                    hdr_q      <= hdr_q << 8;
                    pos        <= pos + 16'd1;
                    if (pos == 16'(HDR - 1)) begin
                        state <= (len_q == 16'd0) ? PAD : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    mac_tx_vld <= 1'b1;
                    mac_tx_eop <= last_byte;
                    mac_tx_dat <= ip_tx_dat;
                    ip_tx_rd   <= rd_next;
                    pos        <= pos + 16'd1;
                    if (pay_last) begin
                        state <= last_byte ? PACE : PAD;
                    end
                end
                PAD: begin
                    mac_tx_vld <= 1'b1;
                    mac_tx_eop <= last_byte;
                    mac_tx_dat <= 8'h00;
                    pos        <= pos + 16'd1;
                    if (last_byte) begin
                        state <= PACE;
                    end
                end
                PACE: begin
                    if (pace_cnt == lim_q) begin
                        state      <= IDLE;
                        frame_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    frame_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_frame_gen.sv
// Directed/randomized bench for mac_tx_frame_gen with a queue-based frame model.
// Define MAC_TX_VLAN_EN to build against the tagged variant.
module tb_mac_tx_frame_gen;

`ifdef MAC_TX_VLAN_EN
    localparam int HDR = 18;
`else
    localparam int HDR = 14;
`endif
    localparam int MIN_PL = 46;
    localparam int PACE_1500 = (1500 + 14) * 8 + 128;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [47:0] local_mac = 48'h0A0B0C0D0E0F;
    logic [47:0] dst_mac = '0;
    logic [15:0] eth_type = '0;
    logic [15:0] vlan_tci = '0;
    logic        ip_tx_req = 1'b0;
    logic [15:0] ip_tx_len = '0;
    logic        ip_tx_ack;
    logic        ip_tx_rd;
    logic [7:0]  ip_tx_dat = '0;
    logic        mac_tx_sop;
    logic        mac_tx_eop;
    logic        mac_tx_vld;
    logic [7:0]  mac_tx_dat;
    logic        frame_busy;
    logic        frame_err;

    mac_tx_frame_gen dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .local_mac  (local_mac),
        .dst_mac    (dst_mac),
        .eth_type   (eth_type),
`ifdef MAC_TX_VLAN_EN
        .vlan_tci   (vlan_tci),
`endif
        .ip_tx_req  (ip_tx_req),
        .ip_tx_len  (ip_tx_len),
        .ip_tx_ack  (ip_tx_ack),
        .ip_tx_rd   (ip_tx_rd),
        .ip_tx_dat  (ip_tx_dat),
        .mac_tx_sop (mac_tx_sop),
        .mac_tx_eop (mac_tx_eop),
        .mac_tx_vld (mac_tx_vld),
        .mac_tx_dat (mac_tx_dat),
        .frame_busy (frame_busy),
        .frame_err  (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];
    int  sop_n, eop_n, sop_idx, eop_idx, bubble, rd_cnt, rd_idx;
    int  ack_n, err_n, err_ack_n, busy_n, cyc, sop_cyc, ack_cyc;
    bit  in_frame, pend;
    logic [7:0] nxt;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance one cycle; emulate upstream read latency and capture the stream.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        ip_tx_dat = pend ? nxt : 8'($urandom);
        pend = 1'b0;
        cyc++;
        if (ip_tx_rd) begin
            rd_cnt++;
            pend = 1'b1;
            nxt = (pl.size() > 0) ? pl[rd_idx % pl.size()] : 8'hEE;
            rd_idx++;
        end
        if (mac_tx_vld) begin
            if (mac_tx_sop) begin
                sop_n++;
                sop_idx = cap.size();
                sop_cyc = cyc;
                in_frame = 1'b1;
            end
            cap.push_back(mac_tx_dat);
            if (mac_tx_eop) begin
                eop_n++;
                eop_idx = cap.size() - 1;
                in_frame = 1'b0;
            end
        end else if (in_frame) begin
            bubble++;
        end
        if (ip_tx_ack) begin
            ack_n++;
            ack_cyc = cyc;
        end
        if (frame_err) err_n++;
        if (frame_err && ip_tx_ack) err_ack_n++;
        if (frame_busy) busy_n++;
    endtask

    task automatic clear_cap();
        cap.delete();
        sop_n = 0; eop_n = 0; sop_idx = -1; eop_idx = -1;
        bubble = 0; rd_cnt = 0; rd_idx = 0; in_frame = 1'b0;
        ack_n = 0; err_n = 0; err_ack_n = 0; busy_n = 0;
    endtask

    task automatic build_exp(input int len);
        exp_q.delete();
        for (int i = 5; i >= 0; i--) exp_q.push_back(dst_mac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(local_mac[i*8 +: 8]);
`ifdef MAC_TX_VLAN_EN
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back(vlan_tci[15:8]);
        exp_q.push_back(vlan_tci[7:0]);
`endif
        exp_q.push_back(eth_type[15:8]);
        exp_q.push_back(eth_type[7:0]);
        for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
        while (exp_q.size() < HDR + MIN_PL) exp_q.push_back(8'h00);
    endtask

    // Raise req, wait for ack, drop req and scramble the sampled inputs.
    task automatic send(input string tag);
        ip_tx_req = 1'b1;
        for (int i = 0; i < 20 && ack_n == 0; i++) tick();
        if (ack_n == 0) check({tag, ".ack_timeout"}, 0, 1);
        ip_tx_req = 1'b0;
        ip_tx_len = 16'($urandom);
        dst_mac = {16'($urandom), 32'($urandom)};
        eth_type = 16'($urandom);
        vlan_tci = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (frame_busy && k < budget) begin
            tick();
            k++;
        end
        if (frame_busy) check({tag, ".idle_timeout"}, 0, 1);
    endtask

    task automatic run_frame(input string tag, input int len, input bit seq);
        int badn;
        clear_cap();
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(seq ? 8'(i) : 8'($urandom));
        if (!seq) begin
            dst_mac = {16'($urandom), 32'($urandom)};
            eth_type = 16'($urandom);
            vlan_tci = 16'($urandom);
        end
        ip_tx_len = 16'(len);
        build_exp(len);
        send(tag);
        tick();
        wait_idle(tag, 20000);
        badn = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) badn++;
        check({tag, ".len"}, cap.size(), exp_q.size());
        check({tag, ".bad_bytes"}, badn, 0);
        check({tag, ".sop_n"}, sop_n, 1);
        check({tag, ".sop_idx"}, sop_idx, 0);
        check({tag, ".eop_n"}, eop_n, 1);
        check({tag, ".eop_idx"}, eop_idx, exp_q.size() - 1);
        check({tag, ".bubble"}, bubble, 0);
        check({tag, ".rd_cnt"}, rd_cnt, len);
        check({tag, ".ack_n"}, ack_n, 1);
        check({tag, ".err_n"}, err_n, 0);
    endtask

    function automatic logic [15:0] outs();
        return {ip_tx_ack, ip_tx_rd, mac_tx_sop, mac_tx_eop, mac_tx_vld,
                mac_tx_dat, frame_busy, frame_err};
    endfunction

    initial begin
        int gap, bl, badn;
        clear_cap();
        pend = 1'b0;
        cyc = 0;

        // Reset state
        sys_rst = 1'b1;
        ip_tx_req = 1'b1;
        tick();
        tick();
        check("reset.outs", outs(), 0);
        ip_tx_req = 1'b0;
        sys_rst = 1'b0;
        tick();
        check("post_reset.outs", outs(), 0);

        // Directed reference frame
        dst_mac = 48'hFFFFFFFFFFFF;
        eth_type = 16'h0800;
        vlan_tci = 16'h0123;
        run_frame("len100", 100, 1'b1);

        run_frame("len10", 10, 1'b0);
        run_frame("len0", 0, 1'b0);
        run_frame("len45", 45, 1'b0);
        run_frame("len46", 46, 1'b0);
        run_frame("len47", 47, 1'b0);
        for (int r = 0; r < 3; r++)
            run_frame($sformatf("rand%0d", r), $urandom_range(0, 120), 1'b0);

        // Rejected length
        clear_cap();
        ip_tx_len = 16'd1501;
        send("len1501");
        for (int i = 0; i < 100; i++) tick();
        check("len1501.err_with_ack", err_ack_n, 1);
        check("len1501.err_n", err_n, 1);
        check("len1501.vld_bytes", cap.size(), 0);
        check("len1501.rd_cnt", rd_cnt, 0);
        check("len1501.busy_cycles", busy_n, 0);
        run_frame("after_err", 64, 1'b0);

        // Back-to-back max frames with req held high
        clear_cap();
        pl.delete();
        for (int i = 0; i < 1500; i++) pl.push_back(8'($urandom));
        dst_mac = {16'($urandom), 32'($urandom)};
        eth_type = 16'($urandom);
        vlan_tci = 16'($urandom);
        ip_tx_len = 16'd1500;
        build_exp(1500);
        ip_tx_req = 1'b1;
        for (int i = 0; i < 20 && ack_n == 0; i++) tick();
        check("b2b.first_ack", ack_n, 1);
        bl = 0;
        for (int i = 0; i < 13000 && ack_n < 2; i++) begin
            tick();
            if (sop_n >= 1 && (cyc - sop_cyc) < PACE_1500 && !frame_busy) bl++;
        end
        ip_tx_req = 1'b0;
        check("b2b.second_ack", ack_n, 2);
        gap = ack_cyc - sop_cyc;
        check("b2b.gap_min", (gap >= PACE_1500) ? PACE_1500 : gap, PACE_1500);
        check("b2b.gap_max", (gap <= PACE_1500 + 3) ? PACE_1500 + 3 : gap,
              PACE_1500 + 3);
        check("b2b.busy_low", bl, 0);
        tick();
        wait_idle("b2b", 20000);
        badn = 0;
        for (int i = 0; i < 2 * exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i % exp_q.size()]) badn++;
        check("b2b.len", cap.size(), 2 * exp_q.size());
        check("b2b.bad_bytes", badn, 0);
        check("b2b.sop_n", sop_n, 2);
        check("b2b.eop_n", eop_n, 2);
        check("b2b.rd_cnt", rd_cnt, 3000);
        check("b2b.bubble", bubble, 0);

        // Reset in the middle of the payload
        clear_cap();
        pl.delete();
        for (int i = 0; i < 200; i++) pl.push_back(8'($urandom));
        ip_tx_len = 16'd200;
        send("midrst");
        for (int i = 0; i < 25; i++) tick();
        check("midrst.in_payload", (rd_cnt > 0 && cap.size() > HDR) ? 1 : 0, 1);
        sys_rst = 1'b1;
        tick();
        check("midrst.outs", outs(), 0);
        sys_rst = 1'b0;
        tick();
        tick();
        check("midrst.idle_outs", outs(), 0);
        run_frame("after_rst46", 46, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_tx_frame_gen.md
Name: mac_tx_frame_gen

Overview:
Upstream MAC framing stage. It takes a payload request from the IP/ARP layer and pulls the payload bytes with a read strobe. It emits a byte stream with the Ethernet header prepended and padding added, as sop/eop/vld/dat into the RMII transmit serializer (FIFO + preamble/CRC stage). It paces frames so the serializer's 2048-entry frame FIFO, drained at one byte per CYC_PER_BYTE clocks, can never overflow.

Parameters:
MAX_LEN, 1500, largest accepted payload length in bytes
MIN_PAYLOAD, 46, minimum payload; shorter payloads are zero-padded up to this
CYC_PER_BYTE, 8, downstream drain rate in sys_clk cycles per byte
OVERHEAD_CYC, 128, extra pacing cycles per frame (preamble + CRC + IFG margin)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
local_mac  in  48  source MAC, byte [47:40] sent first
dst_mac  in  48  destination MAC, byte [47:40] sent first; sampled at ack
eth_type  in  16  EtherType, [15:8] sent first; sampled at ack
ip_tx_req  in  1  level request: a frame is ready upstream
ip_tx_len  in  16  payload length in bytes; sampled at ack
ip_tx_ack  out  1  one-cycle pulse: request accepted, inputs latched
ip_tx_rd  out  1  payload byte read strobe
ip_tx_dat  in  8  payload byte, valid the cycle after ip_tx_rd
mac_tx_sop  out  1  first byte of frame
mac_tx_eop  out  1  last byte of frame
mac_tx_vld  out  1  byte valid
mac_tx_dat  out  8  frame byte
frame_busy  out  1  high from ack until pacing expires
frame_err  out  1  one-cycle pulse: request rejected (length > MAX_LEN)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. A frame in progress is abandoned with no eop; upstream re-requests.
- FSM states: IDLE, HEAD, PAYLOAD, PAD, PACE.
- IDLE + ip_tx_req:
  - Pulse ip_tx_ack.
  - Latch len, dst_mac, eth_type, local_mac.
  - If len > MAX_LEN: pulse frame_err in the same cycle as ack, stay in IDLE, no ip_tx_rd, no output.
  - Otherwise go to HEAD and raise frame_busy.
- HEAD: outputs 14 bytes: dst[6], src[6], type[2]. sop is asserted with the first dst byte. The first header byte appears 1 cycle after ack.
- PAYLOAD: outputs exactly len bytes from ip_tx_dat.
  - ip_tx_rd is issued 2 cycles ahead of the output slot, so header → payload → pad is contiguous with no vld bubbles.
  - ip_tx_rd is asserted exactly len times per frame; it is never asserted for len = 0 or during pad.
- PAD: if len < MIN_PAYLOAD, outputs (MIN_PAYLOAD − len) bytes of 0x00.
- eop is on the last byte. Total frame = 14 + max(len, MIN_PAYLOAD) bytes; vld is continuous from sop to eop inclusive.
- PACE:
  - A 16-bit pacing counter starts at the sop cycle.
  - The FSM returns to IDLE and frame_busy drops when the counter reaches frame_bytes*CYC_PER_BYTE + OVERHEAD_CYC − 1.
  - PACE is entered after eop; the next ack occurs no earlier than the first IDLE cycle.
  - Pacing arithmetic is 16-bit unsigned; maximum 1514*8+128 = 12240, no wrap.
- ip_tx_req while busy is ignored (no ack). A req held high through IDLE is acked once per frame.
- len = 0 is legal and produces 14 header + 46 zero bytes.
- sop and eop never coincide (minimum frame is 60 bytes).

Optional Feature:
MAC_TX_VLAN_EN
- Defined:
  - Adds input vlan_tci[15:0], sampled at ack.
  - A 4-byte 802.1Q tag (0x81,0x00,tci[15:8],tci[7:0]) is inserted between src MAC and eth_type; the header becomes 18 bytes.
  - MIN_PAYLOAD padding is unchanged; frame_bytes includes the tag.
  - ip_tx_rd lead timing is adjusted so output stays contiguous.
- Undefined: no vlan_tci port; 14-byte header.

Test Plan:
- Reset, then req with len=100, dst=FFFFFFFFFFFF, src=0A0B0C0D0E0F, type=0x0800, payload 0..99 → 114 contiguous vld bytes: FF×6, 0A..0F, 08 00, 00..63. sop on byte 0, eop on byte 113. ip_tx_rd count = 100.
- len=10 → 60-byte frame: 10 payload bytes then 36 × 0x00. ip_tx_rd count = 10.
- len=0 → 60-byte frame with 46 zeros; ip_tx_rd never asserted.
- Back-to-back, req held high, len=1500 → second ack no earlier than 1514*8+128 = 12240 cycles after first sop; frame_busy is high throughout.
- len=1501 → ack and frame_err pulse in the same cycle; no vld, no rd; the next valid req is accepted normally.
- Assert sys_rst mid-PAYLOAD → next cycle all outputs 0. A following req with len=46 produces a clean 60-byte frame.
